// File: rtl/game_cmd_pkg.sv
// game_cmd_pkg: command byte layout, object count and decoder FSM encoding
package game_cmd_pkg;
  localparam int TEAM_BIT = 7;
  localparam int ID_MSB = 6;
  localparam int ID_LSB = 4;
  localparam int DIR_YM = 3;
  localparam int DIR_YP = 2;
  localparam int DIR_XM = 1;
  localparam int DIR_XP = 0;
  localparam int BALL_ID = 7;
  localparam int NUM_OBJ = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, APPLY = 2'd2} state_t;
  function automatic logic dir_conflict(input logic [7:0] d);
    return (d[DIR_XP] & d[DIR_XM]) | (d[DIR_YP] & d[DIR_YM]);
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with registered read data; a push while full is accepted only with a same-cycle pop
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic         CLOCK_50,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & !empty;
  assign wr_en = push & (!full | rd_en);
  always_ff @(posedge CLOCK_50)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/game_cmd_decoder.sv
// game_cmd_decoder: buffers UART command bytes, decodes them into per-object direction flags and issues move strobes
// CMD_STICKY_EN: when defined, flags persist across ticks until overwritten by a new command
module game_cmd_decoder
  import game_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV = 65536
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               move_tick,
  output logic [NUM_OBJ-1:0] move_xp,
  output logic [NUM_OBJ-1:0] move_xm,
  output logic [NUM_OBJ-1:0] move_yp,
  output logic [NUM_OBJ-1:0] move_ym,
  output logic [7:0]         cmd_count,
  output logic               err_conflict,
  output logic               fifo_overflow
);
`ifdef CMD_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam int TW = $clog2(TICK_DIV);
  state_t state, state_nx;
  logic pop, cap, apply, full, empty;
  logic [7:0] head, cmd;
  logic [3:0] obj;
  logic [TW-1:0] tick_cnt;
  logic [NUM_OBJ-1:0] f_xp, f_xm, f_yp, f_ym;
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .CLOCK_50,
    .rst,
    .push(rx_valid),
    .pop,
    .wr_data(rx_data),
    .rd_data(head),
    .full,
    .empty
  );
  always_ff @(posedge CLOCK_50) state <= rst ? IDLE : state_nx;
  always_comb state_nx = state == IDLE ? (empty ? IDLE : READ) : state == READ ? APPLY : IDLE;
  always_comb begin
    pop = state == IDLE && !empty;
    cap = state == READ;
    apply = state == APPLY;
  end
  assign obj = {cmd[TEAM_BIT], cmd[ID_MSB:ID_LSB]};
  assign move_tick = tick_cnt == TW'(TICK_DIV - 1);
  assign move_xp = {NUM_OBJ{move_tick}} & f_xp;
  assign move_xm = {NUM_OBJ{move_tick}} & f_xm;
  assign move_yp = {NUM_OBJ{move_tick}} & f_yp;
  assign move_ym = {NUM_OBJ{move_tick}} & f_ym;
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      tick_cnt <= '0;
      cmd <= '0;
      f_xp <= '0;
      f_xm <= '0;
      f_yp <= '0;
      f_ym <= '0;
      cmd_count <= '0;
      err_conflict <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      tick_cnt <= move_tick ? '0 : tick_cnt + 1'b1;
      if (cap) cmd <= head;
      if (move_tick && !STICKY) begin
        f_xp <= '0;
        f_xm <= '0;
        f_yp <= '0;
        f_ym <= '0;
      end
      // the object write follows the tick clear so a same-cycle command survives it
      if (apply && !dir_conflict(cmd)) begin
        f_xp[obj] <= cmd[DIR_XP];
        f_xm[obj] <= cmd[DIR_XM];
        f_yp[obj] <= cmd[DIR_YP];
        f_ym[obj] <= cmd[DIR_YM];
        cmd_count <= cmd_count + 8'd1;
      end
      if (apply && dir_conflict(cmd)) err_conflict <= 1'b1;
      if (rx_valid && full && !pop) fifo_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_game_cmd_decoder.sv
// tb_game_cmd_decoder: directed and randomized checks of game_cmd_decoder against a schedule-based reference model
module tb_game_cmd_decoder;
  localparam int TD = 32;
  localparam int DEPTH = 8;
`ifdef CMD_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic CLOCK_50 = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic move_tick, err_conflict, fifo_overflow;
  logic [15:0] move_xp, move_xm, move_yp, move_ym;
  logic [7:0] cmd_count;
  logic [64:0] obs;
  int checks = 0, errors = 0;

  game_cmd_decoder #(.FIFO_DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .move_tick(move_tick), .move_xp(move_xp), .move_xm(move_xm), .move_yp(move_yp), .move_ym(move_ym),
    .cmd_count(cmd_count), .err_conflict(err_conflict), .fifo_overflow(fifo_overflow)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  assign obs = {move_tick, move_ym, move_yp, move_xm, move_xp};

  // Model: each accepted byte is scheduled to apply 3 cycles after arrival, and no sooner than 3 cycles after
  // the previous one; it leaves the FIFO 2 cycles before it applies.
  int c = 0, mcount = 0, last_ap = -10, occ;
  bit merr = 1'b0, movf = 1'b0;
  logic [3:0] mf [16];
  int q_at [$];
  logic [7:0] q_d [$];
  logic [7:0] md;
  always @(posedge CLOCK_50) begin
    if (rst) begin
      c = 0; mcount = 0; merr = 1'b0; movf = 1'b0; last_ap = -10;
      foreach (mf[i]) mf[i] = 4'h0;
      q_at.delete(); q_d.delete();
    end else begin
      if (rx_valid) begin
        occ = 0;
        foreach (q_at[i]) if (q_at[i] - 2 > c) occ++;
        if (occ >= DEPTH) movf = 1'b1;
        else begin
          last_ap = (c + 3 > last_ap + 3) ? c + 3 : last_ap + 3;
          q_at.push_back(last_ap);
          q_d.push_back(rx_data);
        end
      end
      if (!STICKY && (c % TD) == TD - 1) foreach (mf[i]) mf[i] = 4'h0;
      if (q_at.size() > 0 && q_at[0] == c) begin
        md = q_d.pop_front();
        void'(q_at.pop_front());
        if ((md[0] & md[1]) | (md[2] & md[3])) merr = 1'b1;
        else begin
          mf[md[7:4]] = md[3:0];
          mcount = (mcount + 1) % 256;
        end
      end
      c++;
    end
  end

  function automatic logic [64:0] exp_str();
    logic t;
    logic [15:0] xp, xm, yp, ym;
    t = (c % TD) == TD - 1;
    for (int k = 0; k < 16; k++) begin
      xp[k] = t & mf[k][0];
      xm[k] = t & mf[k][1];
      yp[k] = t & mf[k][2];
      ym[k] = t & mf[k][3];
    end
    return {t, ym, yp, xm, xp};
  endfunction

  task automatic next();
    @(negedge CLOCK_50);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    next();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== 65'd0) begin errors++; $display("FAIL reset_strobes cyc=%0d got=%h want=0", i, obs); end
      checks++;
      if ({cmd_count, err_conflict, fifo_overflow} !== 10'd0)
        begin errors++; $display("FAIL reset_status cyc=%0d got=%h want=0", i, {cmd_count, err_conflict, fifo_overflow}); end
      next();
    end
  endtask

  task automatic test_single();
    int ticks = 0;
    do_reset();
    send(8'h91);
    for (int i = 0; i < 2 * TD + 4 && ticks < 2; i++) begin
      checks++;
      if (obs !== exp_str()) begin errors++; $display("FAIL single_model c=%0d got=%h want=%h", c, obs, exp_str()); end
      if (move_tick) begin
        ticks++;
        checks++;
        if (move_xp !== ((ticks == 1 || STICKY) ? 16'h0200 : 16'h0000))
          begin errors++; $display("FAIL single_xp tick=%0d got=%h", ticks, move_xp); end
        checks++;
        if ({move_xm, move_yp, move_ym} !== 48'd0)
          begin errors++; $display("FAIL single_other tick=%0d got=%h want=0", ticks, {move_xm, move_yp, move_ym}); end
      end
      next();
    end
    checks++;
    if (ticks != 2) begin errors++; $display("FAIL single_ticks got=%0d want=2", ticks); end
    checks++;
    if (cmd_count !== 8'd1) begin errors++; $display("FAIL single_count got=%0d want=1", cmd_count); end
  endtask

  task automatic test_conflict();
    do_reset();
    send(8'h73);
    for (int i = 0; i < 2 * TD + 2; i++) begin
      checks++;
      if ({move_ym, move_yp, move_xm, move_xp} !== 64'd0)
        begin errors++; $display("FAIL conflict_strobes cyc=%0d got=%h want=0", i, obs); end
      next();
    end
    checks++;
    if (err_conflict !== 1'b1) begin errors++; $display("FAIL conflict_err got=%b want=1", err_conflict); end
    checks++;
    if (cmd_count !== 8'd0) begin errors++; $display("FAIL conflict_count got=%0d want=0", cmd_count); end
  endtask

  task automatic test_overflow();
    logic [3:0] j4, n;
    do_reset();
    for (int j = 0; j < 16; j++) begin
      j4 = 4'(j);
      n = 4'($urandom_range(1, 15));
      if ((n[0] & n[1]) | (n[2] & n[3])) n = n & 4'b0101;
      send({j4, n});
    end
    for (int i = 0; i < 3 * TD; i++) begin
      checks++;
      if (obs !== exp_str()) begin errors++; $display("FAIL overflow_model c=%0d got=%h want=%h", c, obs, exp_str()); end
      next();
    end
    checks++;
    if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got=%b want=1", fifo_overflow); end
    checks++;
    if (cmd_count !== 8'd13) begin errors++; $display("FAIL overflow_count got=%0d want=13", cmd_count); end
    checks++;
    if (cmd_count !== 8'(mcount)) begin errors++; $display("FAIL overflow_model_count got=%0d want=%0d", cmd_count, mcount); end
  endtask

  task automatic test_tick_apply();
    int ticks = 0;
    do_reset();
    send(8'h74);
    for (int i = 0; i < TD && (c % TD) != TD - 4; i++) next();
    send(8'h74);
    for (int i = 0; i < 3 * TD + 4 && ticks < 3; i++) begin
      if (move_tick) begin
        ticks++;
        checks++;
        if (move_yp !== ((ticks < 3 || STICKY) ? 16'h0080 : 16'h0000))
          begin errors++; $display("FAIL tick_apply_yp tick=%0d got=%h", ticks, move_yp); end
      end
      next();
    end
    checks++;
    if (ticks != 3) begin errors++; $display("FAIL tick_apply_ticks got=%0d want=3", ticks); end
    checks++;
    if (cmd_count !== 8'd2) begin errors++; $display("FAIL tick_apply_count got=%0d want=2", cmd_count); end
  endtask

`ifdef CMD_STICKY_EN
  task automatic test_sticky();
    int ticks = 0;
    do_reset();
    send(8'h04);
    for (int i = 0; i < 3 * TD + 4 && ticks < 3; i++) begin
      if (move_tick) begin
        ticks++;
        checks++;
        if (move_yp !== 16'h0001) begin errors++; $display("FAIL sticky_yp tick=%0d got=%h want=0001", ticks, move_yp); end
      end
      next();
    end
    checks++;
    if (ticks != 3) begin errors++; $display("FAIL sticky_ticks got=%0d want=3", ticks); end
    send(8'h00);
    for (int i = 0; i < 2 * TD + 2; i++) begin
      checks++;
      if ({move_ym, move_yp, move_xm, move_xp} !== 64'd0)
        begin errors++; $display("FAIL sticky_stop cyc=%0d got=%h want=0", i, obs); end
      next();
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] b [5] = '{8'h11, 8'h22, 8'h34, 8'h48, 8'h51};
    do_reset();
    for (int i = 0; i < 5; i++) send(b[i]);
    rst = 1'b1;
    next();
    rst = 1'b0;
    checks++;
    if (obs !== 65'd0) begin errors++; $display("FAIL reset_mid_strobes got=%h want=0", obs); end
    checks++;
    if ({cmd_count, err_conflict, fifo_overflow} !== 10'd0)
      begin errors++; $display("FAIL reset_mid_status got=%h want=0", {cmd_count, err_conflict, fifo_overflow}); end
    for (int i = 0; i < 2 * TD + 2; i++) begin
      next();
      checks++;
      if ({move_ym, move_yp, move_xm, move_xp} !== 64'd0)
        begin errors++; $display("FAIL reset_mid_later cyc=%0d got=%h want=0", i, obs); end
    end
    checks++;
    if (cmd_count !== 8'd0) begin errors++; $display("FAIL reset_mid_count got=%0d want=0", cmd_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      checks++;
      if (obs !== exp_str()) begin errors++; $display("FAIL random_strobes c=%0d got=%h want=%h", c, obs, exp_str()); end
      checks++;
      if ({cmd_count, err_conflict, fifo_overflow} !== {8'(mcount), merr, movf})
        begin errors++; $display("FAIL random_status c=%0d got=%h want=%h", c, {cmd_count, err_conflict, fifo_overflow}, {8'(mcount), merr, movf}); end
      rx_valid = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rx_data = 8'($urandom);
      next();
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    next();
    test_reset();
    test_single();
    test_conflict();
    test_overflow();
    test_tick_apply();
`ifdef CMD_STICKY_EN
    test_sticky();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
